// File: rtl/apb_uart_regs_if.sv
// APB3 bus bundle between the interconnect (master) and the UART register bank (slave).
interface apb_uart_regs_if #(parameter int ADDR_W = 5);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart_regs.sv
// APB3 register bank for the UART core: control/data out, status in, baud tick,
// and RX holding register with automatic receiver re-arm.
module apb_uart_regs #(
  parameter int          ADDR_W      = 5,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] DIV_RESET   = 16'd433
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_uart_regs_if.slave apb,
  output logic           tx_en,
  output logic           rx_en,
  output logic           tx_rst,
  output logic           rx_rst,
  output logic [7:0]     tx_data,
  output logic           BCLK,
  input  logic           tx_busy,
  input  logic           tx_done,
  input  logic           rx_busy,
  input  logic           rx_done,
  input  logic           rx_error,
  input  logic [7:0]     rx_data
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_ST   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(32'h10);

  state_t      state, state_nx;
  logic [2:0]  wcnt;
  logic        done;
  logic        sel_ctrl, sel_tx, sel_rx, sel_st, sel_div, err, wr, rd;
  logic [31:0] rdata;
  logic [7:0]  rx_hold;
  logic        rx_valid, tx_done_s, rx_err_s, overrun_s;
  logic        rx_done_d, tx_done_d, rx_rise, tx_rise;
  logic [15:0] baud_div, baud_cnt;
  wire         unused_pwdata = &{1'b0, apb.PWDATA[31:16]};

  // The SETUP state registers the bus setup phase, so one PREADY-low cycle
  // always precedes the WAIT_STATES cycles spent in ACCESS.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:    if (apb.PSEL && !apb.PENABLE) state_nx = SETUP;
      SETUP:   state_nx = apb.PSEL ? ACCESS : IDLE;
      ACCESS: begin
        if (!apb.PSEL) state_nx = IDLE;
        else if (wcnt == 3'(WAIT_STATES)) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= (state == ACCESS && !done) ? wcnt + 3'd1 : 3'd0;
    end
  end

  assign sel_ctrl = apb.PADDR == A_CTRL;
  assign sel_tx   = apb.PADDR == A_TX;
  assign sel_rx   = apb.PADDR == A_RX;
  assign sel_st   = apb.PADDR == A_ST;
  assign sel_div  = apb.PADDR == A_DIV;

  assign err = (apb.PADDR[1:0] != 2'b00)
            || !(sel_ctrl || sel_tx || sel_rx || sel_st || sel_div)
            || ( apb.PWRITE && sel_rx)
            || (!apb.PWRITE && sel_tx)
            || ( apb.PWRITE && sel_tx && tx_busy);

  assign wr = done &&  apb.PWRITE && !err;
  assign rd = done && !apb.PWRITE && !err;

  always_comb begin
    rdata = '0;
    if (sel_ctrl) rdata = {30'd0, rx_en, tx_en};
    if (sel_rx)   rdata = {23'd0, rx_valid, rx_hold};
    if (sel_st)   rdata = {26'd0, overrun_s, rx_err_s, rx_valid, rx_busy, tx_done_s, tx_busy};
    if (sel_div)  rdata = {16'd0, baud_div};
  end

  assign apb.PREADY  = done;
  assign apb.PSLVERR = done && err;
  assign apb.PRDATA  = rd ? rdata : 32'd0;

  assign rx_rise = rx_done && !rx_done_d;
  assign tx_rise = tx_done && !tx_done_d;

  // Hardware set events take priority over software clears.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      tx_rst    <= 1'b0;
      rx_rst    <= 1'b0;
      tx_data   <= '0;
      rx_hold   <= '0;
      rx_valid  <= 1'b0;
      tx_done_s <= 1'b0;
      rx_err_s  <= 1'b0;
      overrun_s <= 1'b0;
      rx_done_d <= 1'b0;
      tx_done_d <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      tx_done_d <= tx_done;
      tx_rst    <= wr && sel_ctrl && apb.PWDATA[2];
      rx_rst    <= (wr && sel_ctrl && apb.PWDATA[3]) || rx_rise;
      if (wr && sel_ctrl) begin
        tx_en <= apb.PWDATA[0];
        rx_en <= apb.PWDATA[1];
      end
      if (wr && sel_tx) tx_data <= apb.PWDATA[7:0];

      if (rx_rise) begin
        rx_hold  <= rx_data;
        rx_valid <= 1'b1;
      end else if (wr && sel_ctrl && apb.PWDATA[3]) begin
        rx_hold  <= '0;
        rx_valid <= 1'b0;
      end else if (rd && sel_rx) begin
        rx_valid <= 1'b0;
      end

      if (rx_rise && rx_valid)                 overrun_s <= 1'b1;
      else if (wr && sel_st && apb.PWDATA[5])  overrun_s <= 1'b0;

      if (rx_error)                            rx_err_s <= 1'b1;
      else if (wr && sel_st && apb.PWDATA[4])  rx_err_s <= 1'b0;

      if (tx_rise) tx_done_s <= 1'b1;
      else if (wr && ((sel_st && apb.PWDATA[1]) || (sel_ctrl && apb.PWDATA[2])))
        tx_done_s <= 1'b0;
    end
  end

  // Tick fires the cycle after count==div, giving a period of div+1.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_div <= DIV_RESET;
      baud_cnt <= '0;
      BCLK     <= 1'b0;
    end else if (wr && sel_div) begin
      baud_div <= apb.PWDATA[15:0];
      baud_cnt <= '0;
      BCLK     <= 1'b0;
    end else if (baud_div == 16'd0) begin
      baud_cnt <= '0;
      BCLK     <= 1'b0;
    end else if (baud_cnt == baud_div) begin
      baud_cnt <= '0;
      BCLK     <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
      BCLK     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_uart_regs.sv
// Randomized bench for apb_uart_regs against a register-map level reference model.
module tb_apb_uart_regs;
  localparam int WS = 2;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_uart_regs_if #(.ADDR_W(5)) bus ();
  logic       tx_en, rx_en, tx_rst, rx_rst, BCLK;
  logic [7:0] tx_data;
  logic       tx_busy, tx_done, rx_busy, rx_done, rx_error;
  logic [7:0] rx_data;

  apb_uart_regs #(.ADDR_W(5), .WAIT_STATES(WS), .DIV_RESET(16'd433)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus),
    .tx_en(tx_en), .rx_en(rx_en), .tx_rst(tx_rst), .rx_rst(rx_rst),
    .tx_data(tx_data), .BCLK(BCLK),
    .tx_busy(tx_busy), .tx_done(tx_done), .rx_busy(rx_busy),
    .rx_done(rx_done), .rx_error(rx_error), .rx_data(rx_data)
  );

  int total = 0;
  int bad   = 0;

  int n_txrst = 0, n_rxrst = 0;
  always @(negedge PCLK) begin
    if (tx_rst === 1'b1) n_txrst++;
    if (rx_rst === 1'b1) n_rxrst++;
  end

  // reference model state
  bit         m_tx_en, m_rx_en, m_valid, m_tdone, m_rerr, m_ovr;
  logic [7:0] m_txd, m_hold;
  logic [15:0] m_baud;
  int         m_ntx = 0, m_nrx = 0;

  task automatic m_reset();
    m_tx_en = 0; m_rx_en = 0; m_valid = 0; m_tdone = 0; m_rerr = 0; m_ovr = 0;
    m_txd = 8'h00; m_hold = 8'h00; m_baud = 16'd433;
  endtask

  function automatic bit m_err(input bit wr, input logic [4:0] a);
    if (a[1:0] != 2'b00 || a > 5'h10) return 1'b1;
    if (wr && a == 5'h08) return 1'b1;
    if (a == 5'h04) return !wr || tx_busy;
    return 1'b0;
  endfunction

  task automatic m_access(input bit wr, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] erd, output bit eerr);
    erd  = 32'd0;
    eerr = m_err(wr, a);
    if (eerr) return;
    if (wr) begin
      case (a)
        5'h00: begin
          m_tx_en = d[0]; m_rx_en = d[1];
          if (d[2]) begin m_tdone = 0; m_ntx++; end
          if (d[3]) begin m_hold = 8'h00; m_valid = 0; m_nrx++; end
        end
        5'h04: m_txd = d[7:0];
        5'h0C: begin
          if (d[1]) m_tdone = 0;
          if (d[4]) m_rerr = 0;
          if (d[5]) m_ovr = 0;
        end
        5'h10: m_baud = d[15:0];
        default: ;
      endcase
    end else begin
      case (a)
        5'h00: erd = {30'd0, m_rx_en, m_tx_en};
        5'h08: begin erd = {23'd0, m_valid, m_hold}; m_valid = 0; end
        5'h0C: erd = {26'd0, m_ovr, m_rerr, m_valid, rx_busy, m_tdone, tx_busy};
        5'h10: erd = {16'd0, m_baud};
        default: ;
      endcase
    end
  endtask

  // One APB transfer; PRDATA/PSLVERR must stay 0 until the completing cycle.
  task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int nw);
    bit got = 0;
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    nw = 0; rd = 32'd0; err = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      if (bus.PREADY === 1'b1) begin
        got = 1; rd = bus.PRDATA; err = bus.PSLVERR;
      end else begin
        nw++;
        total++;
        if (bus.PRDATA !== 32'd0 || bus.PSLVERR !== 1'b0) begin
          bad++;
          $display("FAIL early_resp a=%h got prdata=%h pslverr=%b want 0/0", a, bus.PRDATA, bus.PSLVERR);
        end
      end
    end
    total++;
    if (!got) begin bad++; $display("FAIL pready_timeout a=%h got no PREADY want PREADY within 20", a); end
    @(posedge PCLK); #1;
    bus.PSEL = 0; bus.PENABLE = 0;
  endtask

  task automatic xfer(input bit wr, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err,
                      output logic [31:0] erd, output bit eerr, output int nw);
    m_access(wr, a, d, erd, eerr);
    apb(wr, a, d, rd, err, nw);
  endtask

  task automatic rx_event(input logic [7:0] d);
    @(posedge PCLK); #1; rx_data = d; rx_done = 1;
    @(posedge PCLK); #1; rx_done = 0;
    if (m_valid) m_ovr = 1;
    m_hold = d; m_valid = 1; m_nrx++;
    repeat (2) @(posedge PCLK);
  endtask

  task automatic tx_done_event();
    @(posedge PCLK); #1; tx_done = 1;
    @(posedge PCLK); #1; tx_done = 0;
    m_tdone = 1;
  endtask

  task automatic rx_error_event();
    @(posedge PCLK); #1; rx_error = 1;
    @(posedge PCLK); #1; rx_error = 0;
    m_rerr = 1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd; logic err; bit eerr; int nw;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    total++; if (bus.PREADY !== 1'b0) begin bad++; $display("FAIL rst_pready got %b want 0", bus.PREADY); end
    total++; if (BCLK !== 1'b0) begin bad++; $display("FAIL rst_bclk got %b want 0", BCLK); end
    total++; if (bus.PRDATA !== 32'd0 || bus.PSLVERR !== 1'b0) begin bad++; $display("FAIL rst_bus got %h/%b want 0/0", bus.PRDATA, bus.PSLVERR); end
    total++; if ({tx_en, rx_en, tx_rst, rx_rst, tx_data} !== 12'd0) begin bad++; $display("FAIL rst_outs got %h want 0", {tx_en, rx_en, tx_rst, rx_rst, tx_data}); end
    @(posedge PCLK); #1; PRESETn = 1;
    m_reset();
    xfer(0, 5'h10, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== 32'd433 || erd !== 32'd433) begin bad++; $display("FAIL rst_bauddiv got %0d want 433", rd); end
    xfer(0, 5'h00, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd || err !== eerr) begin bad++; $display("FAIL rst_ctrl got %h/%b want %h/%b", rd, err, erd, eerr); end
    xfer(0, 5'h0C, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd) begin bad++; $display("FAIL rst_status got %h want %h", rd, erd); end
  endtask

  task automatic test_ctrl_wait();
    logic [31:0] rd, erd; logic err; bit eerr; int nw;
    xfer(1, 5'h00, 32'h3, rd, err, erd, eerr, nw);
    total++; if (nw !== WS + 1) begin bad++; $display("FAIL wait_states got %0d low cycles want %0d", nw, WS + 1); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ctrl_wr_err got %b want 0", err); end
    total++; if (tx_en !== 1'b1 || rx_en !== 1'b1) begin bad++; $display("FAIL ctrl_en got %b%b want 11", tx_en, rx_en); end
    xfer(0, 5'h00, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd) begin bad++; $display("FAIL ctrl_rd got %h want %h", rd, erd); end
  endtask

  task automatic test_baud();
    logic [31:0] rd, erd; logic err; bit eerr; int nw; int nmis; int nhigh;
    xfer(1, 5'h10, 32'd3, rd, err, erd, eerr, nw);
    nmis = 0; nhigh = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge PCLK);
      if (BCLK === 1'b1) nhigh++;
      if (BCLK !== ((i > 0) && (i % 4 == 0))) nmis++;
    end
    total++; if (nmis != 0 || nhigh != 10) begin bad++; $display("FAIL bclk_div3 got %0d pulses %0d misplaced want 10 pulses 0 misplaced", nhigh, nmis); end
    xfer(1, 5'h10, 32'd0, rd, err, erd, eerr, nw);
    nhigh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (BCLK !== 1'b0) nhigh++;
    end
    total++; if (nhigh != 0) begin bad++; $display("FAIL bclk_div0 got %0d high cycles want 0", nhigh); end
    xfer(0, 5'h10, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd) begin bad++; $display("FAIL baud_rd got %h want %h", rd, erd); end
  endtask

  task automatic test_txdata();
    logic [31:0] rd, erd; logic err; bit eerr; int nw;
    tx_busy = 1;
    xfer(1, 5'h04, 32'hA5, rd, err, erd, eerr, nw);
    total++; if (err !== 1'b1 || tx_data !== m_txd) begin bad++; $display("FAIL tx_busy_wr got err=%b data=%h want 1/%h", err, tx_data, m_txd); end
    tx_busy = 0;
    xfer(1, 5'h04, 32'hA5, rd, err, erd, eerr, nw);
    total++; if (err !== 1'b0 || tx_data !== 8'hA5) begin bad++; $display("FAIL tx_wr got err=%b data=%h want 0/a5", err, tx_data); end
    xfer(0, 5'h04, 0, rd, err, erd, eerr, nw);
    total++; if (err !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL tx_rd got %h/%b want 0/1", rd, err); end
  endtask

  task automatic test_rx();
    logic [31:0] rd, erd; logic err; bit eerr; int nw; int base;
    base = n_rxrst;
    rx_event(8'h3C);
    total++; if (n_rxrst - base != 1) begin bad++; $display("FAIL rx_rearm got %0d pulses want 1", n_rxrst - base); end
    xfer(0, 5'h08, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== 32'h13C || rd !== erd) begin bad++; $display("FAIL rx_rd1 got %h want 13c", rd); end
    xfer(0, 5'h08, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== 32'h03C || rd !== erd) begin bad++; $display("FAIL rx_rd2 got %h want 03c", rd); end
    rx_event(8'h11);
    rx_event(8'h22);
    xfer(0, 5'h0C, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd || rd[5] !== 1'b1) begin bad++; $display("FAIL overrun_set got %h want %h", rd, erd); end
    xfer(1, 5'h0C, 32'h20, rd, err, erd, eerr, nw);
    xfer(0, 5'h0C, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd || rd[5] !== 1'b0) begin bad++; $display("FAIL overrun_w1c got %h want %h", rd, erd); end
    xfer(0, 5'h08, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== 32'h122) begin bad++; $display("FAIL rx_overwrite got %h want 122", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic err; bit eerr; int nw;
    logic [4:0] atab [3] = '{5'h14, 5'h02, 5'h08};
    bit         wtab [3] = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      xfer(wtab[i], atab[i], 32'hFFFF_FFFF, rd, err, erd, eerr, nw);
      total++; if (err !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL slverr a=%h got %h/%b want 0/1", atab[i], rd, err); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; logic err; bit eerr; int nw; bit seen = 0;
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 5'h00; bus.PWDATA = 32'h0;
    @(posedge PCLK); #1; bus.PENABLE = 1;
    repeat (2) begin @(negedge PCLK); if (bus.PREADY === 1'b1) seen = 1; end
    @(posedge PCLK); #1; bus.PSEL = 0; bus.PENABLE = 0;
    repeat (3) @(posedge PCLK);
    #1;
    total++; if (seen || tx_en !== m_tx_en || rx_en !== m_rx_en) begin bad++; $display("FAIL abort got ready=%b en=%b%b want 0/%b%b", seen, tx_en, rx_en, m_tx_en, m_rx_en); end
    xfer(0, 5'h00, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== erd || nw !== WS + 1) begin bad++; $display("FAIL abort_recover got %h/%0d want %h/%0d", rd, nw, erd, WS + 1); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, d; logic err; bit eerr; int nw; bit wr; logic [4:0] a;
    logic [4:0] atab [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h02, 5'h1C};
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0: rx_event(8'($urandom));
        1: tx_done_event();
        2: rx_error_event();
        3: begin @(posedge PCLK); #1; tx_busy = 1'($urandom); rx_busy = 1'($urandom); end
        default: begin
          a  = atab[$urandom_range(0, 7)];
          wr = 1'($urandom);
          d  = $urandom;
          xfer(wr, a, d, rd, err, erd, eerr, nw);
          total++; if (rd !== erd || err !== eerr) begin bad++; $display("FAIL rand_resp wr=%b a=%h got %h/%b want %h/%b", wr, a, rd, err, erd, eerr); end
          total++; if ({tx_en, rx_en, tx_data} !== {m_tx_en, m_rx_en, m_txd}) begin bad++; $display("FAIL rand_outs got %h want %h", {tx_en, rx_en, tx_data}, {m_tx_en, m_rx_en, m_txd}); end
        end
      endcase
    end
    repeat (3) @(posedge PCLK);
    total++; if (n_txrst != m_ntx) begin bad++; $display("FAIL tx_rst_pulses got %0d want %0d", n_txrst, m_ntx); end
    total++; if (n_rxrst != m_nrx) begin bad++; $display("FAIL rx_rst_pulses got %0d want %0d", n_rxrst, m_nrx); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic err; bit eerr; int nw;
    tx_busy = 0; rx_busy = 0;
    xfer(1, 5'h00, 32'h3, rd, err, erd, eerr, nw);
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 5'h10; bus.PWDATA = 32'h5;
    @(posedge PCLK); #1; bus.PENABLE = 1;
    @(posedge PCLK); #1; PRESETn = 0;
    #1;
    total++; if (bus.PREADY !== 1'b0 || tx_en !== 1'b0 || rx_en !== 1'b0) begin bad++; $display("FAIL midrst_state got ready=%b en=%b%b want 0/00", bus.PREADY, tx_en, rx_en); end
    @(posedge PCLK); #1; bus.PSEL = 0; bus.PENABLE = 0;
    @(posedge PCLK); #1; PRESETn = 1;
    m_reset();
    xfer(0, 5'h10, 0, rd, err, erd, eerr, nw);
    total++; if (rd !== 32'd433 || nw !== WS + 1) begin bad++; $display("FAIL midrst_recover got %0d/%0d want 433/%0d", rd, nw, WS + 1); end
  endtask

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
    tx_busy = 0; tx_done = 0; rx_busy = 0; rx_done = 0; rx_error = 0; rx_data = 8'h00;
    m_reset();
    test_reset();
    test_ctrl_wait();
    test_baud();
    test_txdata();
    test_rx();
    test_errors();
    test_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
